// File: rtl/floo_pkg.sv
// ============================================================================
// Module   : floo_pkg
// Brief    : Shared types and defaults for the flit-link VC credit scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package floo_pkg;

  // Shared with the router input buffers so both ends agree on buffer depth.
  localparam int unsigned NumCreditsDefault = 4;
  localparam int unsigned NumVcDefault      = 2;

  localparam int unsigned VcIdWidth      = (NumVcDefault > 1) ? $clog2(NumVcDefault) : 1;
  localparam int unsigned CreditCntWidth = $clog2(NumCreditsDefault + 1);

  typedef logic [VcIdWidth-1:0]      vc_id_t;
  typedef logic [CreditCntWidth-1:0] credit_cnt_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;

  function automatic int unsigned vc_id_width(input int unsigned num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/floo_credit_counter.sv
// ============================================================================
// Module   : floo_credit_counter
// Brief    : Single-VC downstream credit counter, up/down with saturation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module floo_credit_counter
  import floo_pkg::*;
#(
  parameter int unsigned NumCredits  = NumCreditsDefault,
  parameter int unsigned CreditWidth = $clog2(NumCredits + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   inc_i,
  input  logic                   dec_i,
  output logic [CreditWidth-1:0] count_o
);

  localparam logic [CreditWidth-1:0] CountMax = CreditWidth'(NumCredits);

  logic [CreditWidth-1:0] count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= CountMax;
    end else begin
      case ({inc_i, dec_i})
        2'b10: begin
          // A surplus credit is a protocol error; hold rather than wrap.
          if (count != CountMax) begin
            count <= count + 1'b1;
          end
        end
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign count_o = count;

  overflow_chk : assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc_i && !dec_i && (count == CountMax)))
    else $error("credit counter overflow: credit returned while already full");

  underflow_chk : assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && (count == '0)))
    else $error("credit counter underflow: flit sent without credit");

endmodule

`default_nettype wire

// File: rtl/floo_vc_credit_sched.sv
// ============================================================================
// Module   : floo_vc_credit_sched
// Brief    : Credit-based round-robin VC scheduler with wormhole locking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module floo_vc_credit_sched
  import floo_pkg::*;
#(
  parameter int unsigned NumVirtChannels = NumVcDefault,
  parameter int unsigned NumCredits      = NumCreditsDefault,
  parameter type         flit_t          = logic
) (
  input  logic                                                    clk_i,
  input  logic                                                    rst_i,
  input  logic  [NumVirtChannels-1:0]                             valid_i,
  output logic  [NumVirtChannels-1:0]                             ready_o,
  input  flit_t [NumVirtChannels-1:0]                             data_i,
  input  logic  [NumVirtChannels-1:0]                             last_i,
  output logic                                                    valid_o,
  input  logic                                                    ready_i,
  output flit_t                                                   data_o,
  output logic  [vc_id_width(NumVirtChannels)-1:0]                vc_id_o,
  output logic                                                    last_o,
  input  logic  [NumVirtChannels-1:0]                             credit_i,
  output logic  [NumVirtChannels-1:0][$clog2(NumCredits+1)-1:0]   credits_o
);

  localparam int unsigned CreditWidth = $clog2(NumCredits + 1);
  localparam int unsigned VcW         = vc_id_width(NumVirtChannels);

  logic [NumVirtChannels-1:0][CreditWidth-1:0] credits;
  logic [NumVirtChannels-1:0]                  elig;

  sched_state_e   state, state_next;
  logic [VcW-1:0] rr_ptr, rr_next;
  logic [VcW-1:0] lock_vc, lock_next;
  logic [VcW-1:0] rr_sel, rr_idx, sel;
  logic           rr_found;
  logic           link_valid;
  logic           transfer;

  // --------------------------------------------------------------------------
  // Per-VC credit tracking
  // --------------------------------------------------------------------------
  for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
    assign elig[v]    = valid_i[v] && (credits[v] != '0);
    assign ready_o[v] = transfer && (sel == VcW'(v));

    floo_credit_counter #(
      .NumCredits  (NumCredits),
      .CreditWidth (CreditWidth)
    ) i_credit_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (credit_i[v]),
      .dec_i   (ready_o[v]),
      .count_o (credits[v])
    );
  end

  assign credits_o = credits;

  // --------------------------------------------------------------------------
  // Round-robin search: first eligible VC at or after rr_ptr, wrapping
  // --------------------------------------------------------------------------
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_idx   = '0;
    for (int unsigned i = 0; i < NumVirtChannels; i++) begin
      rr_idx = VcW'((32'(rr_ptr) + i) % NumVirtChannels);
      if (!rr_found && elig[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  assign sel        = (state == LOCKED) ? lock_vc : rr_sel;
  assign link_valid = (state == LOCKED) ? elig[lock_vc] : rr_found;

  // --------------------------------------------------------------------------
  // Output datapath; forced quiet while reset is asserted
  // --------------------------------------------------------------------------
  assign valid_o  = link_valid && !rst_i;
  assign transfer = valid_o && ready_i;
  assign data_o   = valid_o ? data_i[sel] : '0;
  assign last_o   = valid_o && last_i[sel];

  if (NumVirtChannels > 1) begin : g_vc_id_multi
    assign vc_id_o = valid_o ? sel : '0;
  end else begin : g_vc_id_single
    assign vc_id_o = '0;
  end

  // --------------------------------------------------------------------------
  // Wormhole lock FSM and round-robin pointer
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    lock_next  = lock_vc;
    rr_next    = rr_ptr;
    if (transfer) begin
      if (last_o) begin
        state_next = IDLE;
        rr_next    = (sel == VcW'(NumVirtChannels - 1)) ? '0 : sel + 1'b1;
      end else begin
        state_next = LOCKED;
        lock_next  = sel;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      lock_vc <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_next;
      lock_vc <= lock_next;
      rr_ptr  <= rr_next;
    end
  end

  no_credit_xfer_chk : assert property (@(posedge clk_i) disable iff (rst_i)
    transfer |-> (credits[sel] != '0))
    else $error("transfer issued on a VC with zero credits");

  ready_onehot_chk : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(ready_o))
    else $error("more than one VC granted in a cycle");

endmodule

`default_nettype wire
